ex: RTL and testbench
=====================

Name: ex

Overview:
- Execute stage; sits directly downstream of the decode stage.
- Consumes aluop/alusel, two resolved operands and the write-back destination.
- Produces write-back data for the ex/mem latch and the ex forwarding bus (ex_reg_write_*) that decode reads.
- Single-cycle for logic, arithmetic and multiply. Integer divide/modulo uses an iterative radix-2 divider that stalls the front end.

Parameters:
- DIV_CYCLES, 32, number of quotient-bit iterations; fixed to the 32-bit datapath.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- aluop_i  in  `ALUOpWidth  operation from decode.
- alusel_i  in  `ALUSelWidth  result-class select from decode.
- reg1_i  in  `RegWidth  operand 1 (rj or imm).
- reg2_i  in  `RegWidth  operand 2 (rk or imm).
- reg_write_addr_i  in  `RegAddrWidth  destination register.
- reg_write_en_i  in  1  destination write enable.
- flush_i  in  1  kill current instruction (branch/exception).
- reg_write_en_o  out  1  write enable to ex/mem and forwarding.
- reg_write_addr_o  out  `RegAddrWidth  destination.
- reg_write_data_o  out  `RegWidth  result.
- stall_req_o  out  1  hold pc, if/id and id/ex.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
- Outputs while rst=1:
  - reg_write_en_o=0, reg_write_addr_o=0, reg_write_data_o=0, stall_req_o=0.
  - FSM goes to IDLE; counter, divider registers and result latch go to 0.
- Logic class (`ALU_SEL_LOGIC):
  - OR/ORI = reg1|reg2; AND = &; NOR = ~(|); XOR = ^.
  - Combinational, 0-cycle.
- Arithmetic class (`ALU_SEL_ARITHMETIC):
  - ADDW/SUBW are mod 2^32.
  - SLT is a signed compare and SLTU an unsigned compare; result is 32'd1 or 32'd0.
- Multiply class (`ALU_SEL_MUL), combinational:
  - MULW = low 32 bits of the product.
  - MULHW = high 32 bits of the signed 64-bit product.
  - MULHWU = high 32 bits of the unsigned 64-bit product.
- Divide class (`ALU_SEL_DIV): DIVW, MODW (signed); DIVWU, MODWU (unsigned).
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Divide op and not flush: latch operand magnitudes, result signs and op; counter=0; stall_req_o=1.
  - If reg2_i==0, go to DONE. Otherwise go to BUSY.
  - Other ops: stall_req_o=0.
- BUSY:
  - One restoring shift-subtract step per cycle; stall_req_o=1.
  - After DIV_CYCLES steps, go to DONE.
- DONE:
  - stall_req_o=0 and the registered result drives reg_write_data_o; the pipeline advances this cycle.
  - Always go to IDLE next.
  - A back-to-back divide starts in the following IDLE cycle.
- Latency: a divide occupies 34 cycles (1 IDLE + 32 BUSY + 1 DONE), with stall asserted for 33 of them. Divide by zero occupies 2 cycles.
- While stall_req_o=1, reg_write_en_o is forced to 0 so decode never forwards a partial result.
- Sign rules:
  - Quotient is negative iff the operand signs differ; remainder takes the dividend's sign.
  - INT_MIN/-1 gives quotient 0x80000000, remainder 0.
- Divide by zero (decided): quotient 0xFFFFFFFF; remainder = dividend.
- flush_i=1 in any state:
  - FSM goes to IDLE next cycle.
  - stall_req_o and reg_write_en_o are 0 that cycle; the result is discarded.
- Unknown aluop/alusel: reg_write_data_o=0; reg_write_en_o passes through.
- reg_write_addr_o always passes reg_write_addr_i.

Decomposition:
- define.v gains:
  - `ALU_MULW, `ALU_MULHW, `ALU_MULHWU, `ALU_DIVW, `ALU_DIVWU, `ALU_MODW, `ALU_MODWU.
  - `ALU_SEL_MUL, `ALU_SEL_DIV.
  - Their opcode2 constants, for decode.
- Sub-module div_unit holds the FSM, counter, shift registers and sign fix-up.
  - Inputs: start, signed_op, dividend, divisor, flush.
  - Outputs: busy, done, quotient, remainder.
- ex holds the combinational ALU, the result mux and the stall/enable gating.

Test Plan:
- ORI reg1=0x0000F0F0, reg2=0x00000F0F, wr_en=1, rd=3 → same cycle data=0x0000FFFF, en=1, addr=3, stall=0.
- SLT reg1=0xFFFFFFFF, reg2=1 → data=1. SLTU with the same operands → data=0.
- MULHW reg1=0x80000000, reg2=2 → 0xFFFFFFFF. MULHWU with the same operands → 0x00000001.
- DIVW 0xFFFFFFF9(-7) by 2 → stall=1 for 33 cycles, en=0 throughout; DONE cycle data=0xFFFFFFFD. MODW with the same operands → 0xFFFFFFFF.
- DIVWU 100 by 0 → stall for 1 cycle, then data=0xFFFFFFFF. MODWU with the same operands → 100.
- DIVW in flight, flush_i pulsed at BUSY cycle 10 → next cycle stall=0, FSM in IDLE. Then ADDW 1+2 → data=3.
- rst asserted mid-BUSY → next edge all outputs 0, stall=0, FSM in IDLE.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared constants for the execute stage: operand widths, ALU op/class encodings,
// decode opcode2 values for the multiply/divide group, and the divider FSM states.
package ex_pkg;

  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALU_OP_W   = 8;
  localparam int ALU_SEL_W  = 3;

  localparam logic [ALU_SEL_W-1:0] ALU_SEL_NOP        = 3'd0;
  localparam logic [ALU_SEL_W-1:0] ALU_SEL_LOGIC      = 3'd1;
  localparam logic [ALU_SEL_W-1:0] ALU_SEL_ARITHMETIC = 3'd2;
  localparam logic [ALU_SEL_W-1:0] ALU_SEL_MUL        = 3'd3;
  localparam logic [ALU_SEL_W-1:0] ALU_SEL_DIV        = 3'd4;

  localparam logic [ALU_OP_W-1:0] ALU_OR     = 8'h01;
  localparam logic [ALU_OP_W-1:0] ALU_AND    = 8'h02;
  localparam logic [ALU_OP_W-1:0] ALU_NOR    = 8'h03;
  localparam logic [ALU_OP_W-1:0] ALU_XOR    = 8'h04;
  localparam logic [ALU_OP_W-1:0] ALU_ADDW   = 8'h10;
  localparam logic [ALU_OP_W-1:0] ALU_SUBW   = 8'h11;
  localparam logic [ALU_OP_W-1:0] ALU_SLT    = 8'h12;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU   = 8'h13;
  localparam logic [ALU_OP_W-1:0] ALU_MULW   = 8'h20;
  localparam logic [ALU_OP_W-1:0] ALU_MULHW  = 8'h21;
  localparam logic [ALU_OP_W-1:0] ALU_MULHWU = 8'h22;
  localparam logic [ALU_OP_W-1:0] ALU_DIVW   = 8'h30;
  localparam logic [ALU_OP_W-1:0] ALU_DIVWU  = 8'h31;
  localparam logic [ALU_OP_W-1:0] ALU_MODW   = 8'h32;
  localparam logic [ALU_OP_W-1:0] ALU_MODWU  = 8'h33;

  // Upper 17 instruction bits of the 3R-format multiply/divide group, matched by decode.
  localparam logic [16:0] OPC2_MULW   = 17'h00038;
  localparam logic [16:0] OPC2_MULHW  = 17'h00039;
  localparam logic [16:0] OPC2_MULHWU = 17'h0003a;
  localparam logic [16:0] OPC2_DIVW   = 17'h00040;
  localparam logic [16:0] OPC2_MODW   = 17'h00041;
  localparam logic [16:0] OPC2_DIVWU  = 17'h00042;
  localparam logic [16:0] OPC2_MODWU  = 17'h00043;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic [REG_W-1:0] magnitude(input logic [REG_W-1:0] v,
                                                 input logic is_signed);
    return (is_signed && v[REG_W-1]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_div_unit.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle on operand
// magnitudes, with sign fix-up folded into the final step and a registered result.
module ex_div_unit
  import ex_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_op_i,
  input  logic [REG_W-1:0] dividend_i,
  input  logic [REG_W-1:0] divisor_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [REG_W-1:0] quotient_o,
  output logic [REG_W-1:0] remainder_o
);

  localparam int CNT_W = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_CYCLES - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [REG_W-1:0] rem_q, rem_d;
  logic [REG_W-1:0] quo_q, quo_d;
  logic [REG_W-1:0] dvs_q, dvs_d;
  logic [REG_W-1:0] quot_res_q, quot_res_d;
  logic [REG_W-1:0] rem_res_q, rem_res_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;

  logic [REG_W:0]   trial;
  logic [REG_W-1:0] rem_step;
  logic [REG_W-1:0] quo_step;
  logic             last_step;
  logic             div_by_zero;

  assign last_step   = (cnt_q == LAST_CNT);
  assign div_by_zero = (divisor_i == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = DIV_IDLE;
    end else begin
      case (state_q)
        DIV_IDLE: if (start_i) state_d = div_by_zero ? DIV_DONE : DIV_BUSY;
        DIV_BUSY: if (last_step) state_d = DIV_DONE;
        DIV_DONE: state_d = DIV_IDLE;
        default:  state_d = DIV_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    if (!rst && !flush_i) begin
      case (state_q)
        DIV_IDLE: busy_o = start_i;
        DIV_BUSY: busy_o = 1'b1;
        DIV_DONE: done_o = 1'b1;
        default:  ;
      endcase
    end
  end

  // Shift the next dividend bit into the partial remainder; keep the difference if it did not borrow.
  always_comb begin
    trial    = {rem_q, quo_q[REG_W-1]} - {1'b0, dvs_q};
    rem_step = trial[REG_W] ? {rem_q[REG_W-2:0], quo_q[REG_W-1]} : trial[REG_W-1:0];
    quo_step = {quo_q[REG_W-2:0], ~trial[REG_W]};
  end

  always_comb begin
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    quot_res_d = quot_res_q;
    rem_res_d  = rem_res_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    case (state_q)
      DIV_IDLE: begin
        if (start_i && !flush_i) begin
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = magnitude(dividend_i, signed_op_i);
          dvs_d   = magnitude(divisor_i, signed_op_i);
          q_neg_d = signed_op_i & (dividend_i[REG_W-1] ^ divisor_i[REG_W-1]);
          r_neg_d = signed_op_i & dividend_i[REG_W-1];
          if (div_by_zero) begin
            quot_res_d = '1;
            rem_res_d  = dividend_i;
          end
        end
      end
      DIV_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        rem_d = rem_step;
        quo_d = quo_step;
        if (last_step) begin
          quot_res_d = q_neg_q ? -quo_step : quo_step;
          rem_res_d  = r_neg_q ? -rem_step : rem_step;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      quot_res_q <= '0;
      rem_res_q  <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      quot_res_q <= quot_res_d;
      rem_res_q  <= rem_res_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
    end
  end

  assign quotient_o  = quot_res_q;
  assign remainder_o = rem_res_q;

endmodule

// File: rtl/ex.sv
// Execute stage: single-cycle logic/arithmetic/multiply, plus an iterative divider
// that stalls the front end and hides partial results from the forwarding bus.
module ex
  import ex_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ALU_OP_W-1:0]   aluop_i,
  input  logic [ALU_SEL_W-1:0]  alusel_i,
  input  logic [REG_W-1:0]      reg1_i,
  input  logic [REG_W-1:0]      reg2_i,
  input  logic [REG_ADDR_W-1:0] reg_write_addr_i,
  input  logic                  reg_write_en_i,
  input  logic                  flush_i,
  output logic                  reg_write_en_o,
  output logic [REG_ADDR_W-1:0] reg_write_addr_o,
  output logic [REG_W-1:0]      reg_write_data_o,
  output logic                  stall_req_o
);

  logic [REG_W-1:0]   logic_res;
  logic [REG_W-1:0]   arith_res;
  logic [REG_W-1:0]   mul_res;
  logic [REG_W-1:0]   result;
  logic [2*REG_W-1:0] u_prod;
  logic [REG_W-1:0]   mulh_s;

  logic             is_div_op;
  logic             div_signed;
  logic             div_is_mod;
  logic             div_start;
  logic             div_busy;
  logic             div_done;
  logic [REG_W-1:0] div_quot;
  logic [REG_W-1:0] div_rem;

  always_comb begin
    logic_res = '0;
    case (aluop_i)
      ALU_OR:  logic_res = reg1_i | reg2_i;
      ALU_AND: logic_res = reg1_i & reg2_i;
      ALU_NOR: logic_res = ~(reg1_i | reg2_i);
      ALU_XOR: logic_res = reg1_i ^ reg2_i;
      default: ;
    endcase
  end

  always_comb begin
    arith_res = '0;
    case (aluop_i)
      ALU_ADDW: arith_res = reg1_i + reg2_i;
      ALU_SUBW: arith_res = reg1_i - reg2_i;
      ALU_SLT:  arith_res = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
      ALU_SLTU: arith_res = {31'd0, reg1_i < reg2_i};
      default:  ;
    endcase
  end

  // One unsigned multiplier; the signed high word is corrected by subtracting each
  // operand where the other is negative (exact modulo 2^32).
  assign u_prod = {{REG_W{1'b0}}, reg1_i} * {{REG_W{1'b0}}, reg2_i};
  assign mulh_s = u_prod[2*REG_W-1:REG_W]
                  - (reg1_i[REG_W-1] ? reg2_i : '0)
                  - (reg2_i[REG_W-1] ? reg1_i : '0);

  always_comb begin
    mul_res = '0;
    case (aluop_i)
      ALU_MULW:   mul_res = u_prod[REG_W-1:0];
      ALU_MULHW:  mul_res = mulh_s;
      ALU_MULHWU: mul_res = u_prod[2*REG_W-1:REG_W];
      default:    ;
    endcase
  end

  always_comb begin
    is_div_op  = 1'b0;
    div_signed = 1'b0;
    div_is_mod = 1'b0;
    if (alusel_i == ALU_SEL_DIV) begin
      case (aluop_i)
        ALU_DIVW:  begin is_div_op = 1'b1; div_signed = 1'b1; end
        ALU_DIVWU: begin is_div_op = 1'b1; end
        ALU_MODW:  begin is_div_op = 1'b1; div_signed = 1'b1; div_is_mod = 1'b1; end
        ALU_MODWU: begin is_div_op = 1'b1; div_is_mod = 1'b1; end
        default:   ;
      endcase
    end
  end

  assign div_start = is_div_op;

  ex_div_unit #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div (
    .clk         (clk),
    .rst         (rst),
    .start_i     (div_start),
    .signed_op_i (div_signed),
    .dividend_i  (reg1_i),
    .divisor_i   (reg2_i),
    .flush_i     (flush_i),
    .busy_o      (div_busy),
    .done_o      (div_done),
    .quotient_o  (div_quot),
    .remainder_o (div_rem)
  );

  always_comb begin
    result = '0;
    case (alusel_i)
      ALU_SEL_LOGIC:      result = logic_res;
      ALU_SEL_ARITHMETIC: result = arith_res;
      ALU_SEL_MUL:        result = mul_res;
      ALU_SEL_DIV:        if (is_div_op && div_done) result = div_is_mod ? div_rem : div_quot;
      default:            ;
    endcase
  end

  // A stalled or flushed instruction must never appear on the forwarding bus.
  assign stall_req_o      = div_busy;
  assign reg_write_en_o   = ~rst & reg_write_en_i & ~div_busy & ~flush_i;
  assign reg_write_addr_o = rst ? '0 : reg_write_addr_i;
  assign reg_write_data_o = rst ? '0 : result;

endmodule

// File: tb/tb_ex.sv
// Directed bench for the execute stage: expectations are queued when an op is
// driven and popped when the stage presents its write-back result.
module tb_ex;
  import ex_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [ALU_OP_W-1:0]   aluop_i;
  logic [ALU_SEL_W-1:0]  alusel_i;
  logic [REG_W-1:0]      reg1_i;
  logic [REG_W-1:0]      reg2_i;
  logic [REG_ADDR_W-1:0] reg_write_addr_i;
  logic                  reg_write_en_i;
  logic                  flush_i;
  logic                  reg_write_en_o;
  logic [REG_ADDR_W-1:0] reg_write_addr_o;
  logic [REG_W-1:0]      reg_write_data_o;
  logic                  stall_req_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string            tag;
    logic [REG_W-1:0] data;
    logic             en;
    logic [4:0]       addr;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  ex #(.DIV_CYCLES(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .aluop_i          (aluop_i),
    .alusel_i         (alusel_i),
    .reg1_i           (reg1_i),
    .reg2_i           (reg2_i),
    .reg_write_addr_i (reg_write_addr_i),
    .reg_write_en_i   (reg_write_en_i),
    .flush_i          (flush_i),
    .reg_write_en_o   (reg_write_en_o),
    .reg_write_addr_o (reg_write_addr_o),
    .reg_write_data_o (reg_write_data_o),
    .stall_req_o      (stall_req_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic wen);
    alusel_i         = sel;
    aluop_i          = op;
    reg1_i           = a;
    reg2_i           = b;
    reg_write_addr_i = rd;
    reg_write_en_i   = wen;
  endtask

  task automatic pop_check();
    exp_t e;
    chk("sb_depth", 32'(sb_q.size()), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({e.tag, "_data"}, reg_write_data_o, e.data);
      chk({e.tag, "_en"}, {31'd0, reg_write_en_o}, {31'd0, e.en});
      chk({e.tag, "_addr"}, {27'd0, reg_write_addr_o}, {27'd0, e.addr});
      $display("txn %s data=0x%08h en=%0b addr=%0d", e.tag, reg_write_data_o,
               reg_write_en_o, reg_write_addr_o);
    end
  endtask

  // Single-cycle op: result is visible in the same cycle it is driven.
  task automatic single(input string tag, input logic [2:0] sel, input logic [7:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_data);
    drive(sel, op, a, b, rd, 1'b1);
    sb_q.push_back('{tag, exp_data, 1'b1, rd});
    @(negedge clk);
    chk({tag, "_stall"}, {31'd0, stall_req_o}, 32'd0);
    pop_check();
    @(posedge clk);
    #1;
  endtask

  task automatic do_div(input string tag, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_data, input int exp_stall);
    int n;
    drive(ALU_SEL_DIV, op, a, b, rd, 1'b1);
    sb_q.push_back('{tag, exp_data, 1'b1, rd});
    n = 0;
    @(negedge clk);
    while (stall_req_o === 1'b1 && n < 100) begin
      chk({tag, "_en_in_stall"}, {31'd0, reg_write_en_o}, 32'd0);
      n++;
      @(negedge clk);
    end
    chk({tag, "_stall_cycles"}, 32'(n), 32'(exp_stall));
    pop_check();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    flush_i = 1'b0;
    drive(ALU_SEL_LOGIC, ALU_OR, 32'h0000F0F0, 32'h00000F0F, 5'd7, 1'b1);
    @(negedge clk);
    chk("rst_en", {31'd0, reg_write_en_o}, 32'd0);
    chk("rst_addr", {27'd0, reg_write_addr_o}, 32'd0);
    chk("rst_data", reg_write_data_o, 32'd0);
    chk("rst_stall", {31'd0, stall_req_o}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    single("ori",   ALU_SEL_LOGIC, ALU_OR,  32'h0000F0F0, 32'h00000F0F, 5'd3, 32'h0000FFFF);
    single("and",   ALU_SEL_LOGIC, ALU_AND, 32'hFF00FF00, 32'h0FF00FF0, 5'd4, 32'h0F000F00);
    single("nor",   ALU_SEL_LOGIC, ALU_NOR, 32'h0000FFFF, 32'h00FF0000, 5'd5, 32'hFF000000);
    single("xor",   ALU_SEL_LOGIC, ALU_XOR, 32'hAAAA5555, 32'hFFFF0000, 5'd6, 32'h55555555);
    single("addw",  ALU_SEL_ARITHMETIC, ALU_ADDW, 32'hFFFFFFFF, 32'd2, 5'd8, 32'd1);
    single("subw",  ALU_SEL_ARITHMETIC, ALU_SUBW, 32'd0, 32'd1, 5'd9, 32'hFFFFFFFF);
    single("slt",   ALU_SEL_ARITHMETIC, ALU_SLT,  32'hFFFFFFFF, 32'd1, 5'd10, 32'd1);
    single("sltu",  ALU_SEL_ARITHMETIC, ALU_SLTU, 32'hFFFFFFFF, 32'd1, 5'd11, 32'd0);
    single("mulw",  ALU_SEL_MUL, ALU_MULW,   32'h12345678, 32'h00000010, 5'd12, 32'h23456780);
    single("mulhw", ALU_SEL_MUL, ALU_MULHW,  32'h80000000, 32'd2, 5'd13, 32'hFFFFFFFF);
    single("mulhwu", ALU_SEL_MUL, ALU_MULHWU, 32'h80000000, 32'd2, 5'd14, 32'h00000001);
    single("unk_op",  ALU_SEL_LOGIC, 8'hFF, 32'h12345678, 32'h1, 5'd15, 32'd0);
    single("unk_sel", 3'd7, ALU_OR, 32'h12345678, 32'h1, 5'd16, 32'd0);

    drive(ALU_SEL_LOGIC, ALU_OR, 32'h1, 32'h2, 5'd17, 1'b1);
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush_alu_en", {31'd0, reg_write_en_o}, 32'd0);
    chk("flush_alu_stall", {31'd0, stall_req_o}, 32'd0);
    @(posedge clk);
    #1;
    flush_i = 1'b0;

    do_div("divw_neg",  ALU_DIVW,  32'hFFFFFFF9, 32'd2, 5'd18, 32'hFFFFFFFD, 33);
    do_div("modw_neg",  ALU_MODW,  32'hFFFFFFF9, 32'd2, 5'd18, 32'hFFFFFFFF, 33);
    do_div("divwu_z",   ALU_DIVWU, 32'd100, 32'd0, 5'd19, 32'hFFFFFFFF, 1);
    do_div("modwu_z",   ALU_MODWU, 32'd100, 32'd0, 5'd19, 32'd100, 1);
    do_div("modw_z",    ALU_MODW,  32'hFFFFFFFB, 32'd0, 5'd20, 32'hFFFFFFFB, 1);
    do_div("divw_min",  ALU_DIVW,  32'h80000000, 32'hFFFFFFFF, 5'd21, 32'h80000000, 33);
    do_div("modw_min",  ALU_MODW,  32'h80000000, 32'hFFFFFFFF, 5'd21, 32'd0, 33);
    do_div("divwu_big", ALU_DIVWU, 32'hFFFFFFFF, 32'd3, 5'd22, 32'h55555555, 33);
    do_div("modwu_big", ALU_MODWU, 32'hFFFFFFFF, 32'd7, 5'd22, 32'd3, 33);
    do_div("divw_nd",   ALU_DIVW,  32'd7, 32'hFFFFFFFE, 5'd23, 32'hFFFFFFFD, 33);
    do_div("modw_nd",   ALU_MODW,  32'd7, 32'hFFFFFFFE, 5'd23, 32'd1, 33);

    // Flush a divide at its tenth BUSY cycle, then show the FSM is idle again.
    drive(ALU_SEL_DIV, ALU_DIVW, 32'd1000, 32'd7, 5'd24, 1'b1);
    @(negedge clk);
    chk("flushdiv_idle_stall", {31'd0, stall_req_o}, 32'd1);
    for (int i = 0; i < 10; i++) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(negedge clk);
    chk("flushdiv_stall", {31'd0, stall_req_o}, 32'd0);
    chk("flushdiv_en", {31'd0, reg_write_en_o}, 32'd0);
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    single("addw_after_flush", ALU_SEL_ARITHMETIC, ALU_ADDW, 32'd1, 32'd2, 5'd25, 32'd3);

    // Reset in the middle of a divide.
    drive(ALU_SEL_DIV, ALU_DIVW, 32'h12345678, 32'd3, 5'd26, 1'b1);
    for (int i = 0; i < 5; i++) @(posedge clk);
    #1;
    rst = 1'b1;
    drive(ALU_SEL_LOGIC, ALU_OR, 32'h0000F0F0, 32'h00000F0F, 5'd27, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("midrst_en", {31'd0, reg_write_en_o}, 32'd0);
    chk("midrst_addr", {27'd0, reg_write_addr_o}, 32'd0);
    chk("midrst_data", reg_write_data_o, 32'd0);
    chk("midrst_stall", {31'd0, stall_req_o}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    single("ori_after_rst", ALU_SEL_LOGIC, ALU_OR, 32'h0000F0F0, 32'h00000F0F, 5'd27, 32'h0000FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
